// File: rtl/fsm_counter_gen.sv
`default_nettype none
// ============================================================================
//  Module   : fsm_counter_gen
//  Purpose  : Parametrised up/down sequence generator with synchronous load,
//             count enable and three end-of-range modes (wrap, saturate,
//             ping-pong). Emits a registered one-cycle terminal-count pulse
//             and an effective-direction flag.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH    counter / data width in bits (>= 2)
//    MAX_VAL  highest legal count, range is 0..MAX_VAL
//    STEP     increment per enabled cycle (1..MAX_VAL)
//  Ports
//    clk   in   1      clock, rising edge
//    rst   in   1      synchronous reset, active-low
//    ce    in   1      count enable
//    load  in   1      synchronous load of data (ce not required)
//    up    in   1      commanded direction, 1 = up
//    mode  in   2      00 wrap, 01 saturate, 10 ping-pong, 11 as 00
//    data  in   WIDTH  load value (clamped to MAX_VAL)
//    seq   out  WIDTH  current count
//    tc    out  1      terminal-count pulse
//    dir   out  1      effective direction, 1 = up
// ============================================================================
module fsm_counter_gen #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 15,
  parameter int STEP    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             load,
  input  logic             up,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] seq,
  output logic             tc,
  output logic             dir
);

  // Extended-width constants for bound comparisons (no silent overflow).
  localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
  // WIDTH-bit constants for result arithmetic. Every result lies in
  // 0..MAX_VAL, so modular WIDTH-bit arithmetic yields the exact value even
  // when MAX_VAL+1 wraps to zero in WIDTH bits.
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] MOD_W  = WIDTH'(MAX_VAL + 1);

  localparam logic [1:0] MODE_SAT  = 2'b01;
  localparam logic [1:0] MODE_PING = 2'b10;

  typedef enum logic {
    RUN_DOWN = 1'b0,
    RUN_UP   = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] seq_n;
  logic             tc_n;
  logic [WIDTH:0]   seq_x;
  logic [WIDTH:0]   sum_x;

  // State, count and pulse registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN_UP;
      seq   <= '0;
      tc    <= 1'b0;
    end else begin
      state <= state_n;
      seq   <= seq_n;
      tc    <= tc_n;
    end
  end

  // The state register always holds the effective direction: it follows
  // 'up' on load and on wrap/saturate counting edges, and is the ping-pong
  // FSM state otherwise.
  assign dir = (state == RUN_UP);

  always_comb begin
    seq_x   = {1'b0, seq};
    sum_x   = seq_x + STEP_X;
    state_n = state;
    seq_n   = seq;
    tc_n    = 1'b0;

    if (load) begin
      seq_n   = ({1'b0, data} > MAX_X) ? MAX_W : data;
      state_n = up ? RUN_UP : RUN_DOWN;
    end else if (ce) begin
      case (mode)
        MODE_SAT: begin
          state_n = up ? RUN_UP : RUN_DOWN;
          if (up) begin
            if (sum_x >= MAX_X) begin
              seq_n = MAX_W;
              tc_n  = (seq != MAX_W);   // no pulse while parked at the top
            end else begin
              seq_n = seq + STEP_W;
            end
          end else begin
            if (seq_x <= STEP_X) begin
              seq_n = '0;
              tc_n  = (seq != '0);      // no pulse while parked at zero
            end else begin
              seq_n = seq - STEP_W;
            end
          end
        end

        MODE_PING: begin
          if (state == RUN_UP) begin
            if (sum_x >= MAX_X) begin
              seq_n   = MAX_W;
              state_n = RUN_DOWN;
              tc_n    = 1'b1;
            end else begin
              seq_n = seq + STEP_W;
            end
          end else begin
            if (seq_x <= STEP_X) begin
              seq_n   = '0;
              state_n = RUN_UP;
              tc_n    = 1'b1;
            end else begin
              seq_n = seq - STEP_W;
            end
          end
        end

        default: begin  // wrap (00 and 11)
          state_n = up ? RUN_UP : RUN_DOWN;
          if (up) begin
            if (sum_x > MAX_X) begin
              seq_n = seq + STEP_W - MOD_W;
              tc_n  = 1'b1;
            end else begin
              seq_n = seq + STEP_W;
            end
          end else begin
            if (seq_x < STEP_X) begin
              seq_n = seq + MOD_W - STEP_W;
              tc_n  = 1'b1;
            end else begin
              seq_n = seq - STEP_W;
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fsm_counter_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fsm_counter_gen
//  Purpose  : Directed self-checking bench for fsm_counter_gen. Two instances
//             share all inputs: one with STEP=1, one with STEP=4 (both
//             WIDTH=4, MAX_VAL=9).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fsm_counter_gen;

  logic       clk = 1'b0;
  logic       rst, ce, load, up;
  logic [1:0] mode;
  logic [3:0] data;
  logic [3:0] seq1, seq4;
  logic       tc1, tc4, dir1, dir4;

  int checks   = 0;
  int failures = 0;

  int pp_seq [12] = '{8, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1};
  int pp_tc  [12] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
  int pp_dir [12] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
  int s4_seq [5]  = '{4, 8, 2, 6, 0};
  int s4_tc  [5]  = '{0, 0, 1, 0, 1};

  always #5 clk = ~clk;

  fsm_counter_gen #(.WIDTH(4), .MAX_VAL(9), .STEP(1)) dut1 (
    .clk(clk), .rst(rst), .ce(ce), .load(load), .up(up), .mode(mode),
    .data(data), .seq(seq1), .tc(tc1), .dir(dir1)
  );

  fsm_counter_gen #(.WIDTH(4), .MAX_VAL(9), .STEP(4)) dut4 (
    .clk(clk), .rst(rst), .ce(ce), .load(load), .up(up), .mode(mode),
    .data(data), .seq(seq4), .tc(tc4), .dir(dir4)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; ce = 1'b0; load = 1'b0; up = 1'b1; mode = 2'b00; data = 4'd0;

    // ---- 1: reset, then wrap up 0..9,0,1
    tick(); tick();
    chk("rst_seq", int'(seq1), 0);
    chk("rst_tc",  int'(tc1),  0);
    chk("rst_dir", int'(dir1), 1);
    rst = 1'b1; ce = 1'b1; up = 1'b1; mode = 2'b00;
    for (int i = 1; i <= 11; i++) begin
      tick();
      chk($sformatf("wrap_up_seq%0d", i), int'(seq1), i % 10);
      chk($sformatf("wrap_up_tc%0d", i),  int'(tc1),  (i == 10) ? 1 : 0);
      chk($sformatf("wrap_up_dir%0d", i), int'(dir1), 1);
    end

    // ---- 2: clamped load, then wrap down 8..0,9
    load = 1'b1; data = 4'hC; up = 1'b0;
    tick();
    chk("load_clamp_seq", int'(seq1), 9);
    chk("load_clamp_tc",  int'(tc1),  0);
    chk("load_clamp_dir", int'(dir1), 0);
    load = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("wrap_dn_seq%0d", i), int'(seq1), (i <= 9) ? 9 - i : 9);
      chk($sformatf("wrap_dn_tc%0d", i),  int'(tc1),  (i == 10) ? 1 : 0);
      chk($sformatf("wrap_dn_dir%0d", i), int'(dir1), 0);
    end

    // ---- 3: saturate up from 7 -> 8,9,9,9
    load = 1'b1; data = 4'd7; up = 1'b1; mode = 2'b01;
    tick();
    chk("sat_load_seq", int'(seq1), 7);
    load = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("sat_seq%0d", i), int'(seq1), (i == 1) ? 8 : 9);
      chk($sformatf("sat_tc%0d", i),  int'(tc1),  (i == 2) ? 1 : 0);
    end
    // saturate down to 0, pulse once on arrival
    up = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      chk($sformatf("satdn_seq%0d", i), int'(seq1), (i <= 9) ? 9 - i : 0);
      chk($sformatf("satdn_tc%0d", i),  int'(tc1),  (i == 9) ? 1 : 0);
    end

    // ---- 4: ping-pong from 7; up input ignored while counting
    load = 1'b1; data = 4'd7; up = 1'b1; mode = 2'b10;
    tick();
    chk("pp_load_seq", int'(seq1), 7);
    chk("pp_load_dir", int'(dir1), 1);
    load = 1'b0; up = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("pp_seq%0d", i), int'(seq1), pp_seq[i]);
      chk($sformatf("pp_tc%0d", i),  int'(tc1),  pp_tc[i]);
      chk($sformatf("pp_dir%0d", i), int'(dir1), pp_dir[i]);
    end

    // ---- 6: reset wins over load and ce, then hold
    rst = 1'b0; load = 1'b1; ce = 1'b1; data = 4'd5; up = 1'b0;
    tick();
    chk("rst_prio_seq", int'(seq1), 0);
    chk("rst_prio_tc",  int'(tc1),  0);
    chk("rst_prio_dir", int'(dir1), 1);
    rst = 1'b1; load = 1'b0; ce = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("hold_seq%0d", i), int'(seq1), 0);
      chk($sformatf("hold_tc%0d", i),  int'(tc1),  0);
    end

    // ---- 5: STEP=4 instance, wrap up from 0, then down from 2
    rst = 1'b0;
    tick();
    chk("s4_rst_seq", int'(seq4), 0);
    rst = 1'b1; ce = 1'b1; up = 1'b1; mode = 2'b00;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("s4_up_seq%0d", i), int'(seq4), s4_seq[i]);
      chk($sformatf("s4_up_tc%0d", i),  int'(tc4),  s4_tc[i]);
    end
    load = 1'b1; data = 4'd2; up = 1'b0;
    tick();
    chk("s4_load_seq", int'(seq4), 2);
    load = 1'b0;
    tick();
    chk("s4_dn_seq", int'(seq4), 8);
    chk("s4_dn_tc",  int'(tc4),  1);
    chk("s4_dn_dir", int'(dir4), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
